pipe_perf_monitor: RTL and testbench

Cycle-accurate performance monitor for the 5-stage pipelined CPU. It taps hazard-detection, control and writeback signals and keeps saturating counters for cycles, stalls, flushes and retired instructions. It also buffers the PC of every flushed fetch in a small trace FIFO and enforces a run-cycle limit. It sits beside the CPU top level as the consumer of its pipeline status, and replaces ad-hoc bench counting.

---
 rtl/pipe_perf_monitor_if.sv | 19 +
 rtl/pipe_perf_monitor.sv | 155 +++++++++++++++
 tb/tb_pipe_perf_monitor.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_perf_monitor_if.sv
// Flush-PC trace port of the pipeline performance monitor.
// The monitor drives the head of its trace FIFO; the consumer acknowledges entries.
interface pipe_perf_monitor_if;
    logic        trace_valid_o;
    logic [31:0] trace_pc_o;
    logic        trace_ready_i;

    modport master (
        output trace_valid_o,
        output trace_pc_o,
        input  trace_ready_i
    );

    modport slave (
        input  trace_valid_o,
        input  trace_pc_o,
        output trace_ready_i
    );
endinterface

// File: rtl/pipe_perf_monitor.sv
// Pipeline performance monitor: saturating cycle/stall/flush/retire counters,
// an IDLE/RUN/DONE run-length FSM and a FIFO tracing the PC of every flushed fetch.
module pipe_perf_monitor #(
    parameter int CNT_W      = 32,
    parameter int MAX_CYCLES = 30,
    parameter int FIFO_DEPTH = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic               clear_i,
    input  logic               stall_i,
    input  logic               flush_i,
    input  logic               jump_i,
    input  logic               branch_i,
    input  logic               retire_i,
    input  logic [31:0]        pc_i,
    output logic [CNT_W-1:0]   cycle_cnt_o,
    output logic [CNT_W-1:0]   stall_cnt_o,
    output logic [CNT_W-1:0]   flush_cnt_o,
    output logic [CNT_W-1:0]   retire_cnt_o,
    output logic               running_o,
    output logic               done_o,
    output logic               overflow_o,
    pipe_perf_monitor_if.master trace
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cycle_q, cycle_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;
    logic [CNT_W-1:0] retire_q, retire_d;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PTR_W:0]   wr_ptr_q, rd_ptr_q;
    logic             overflow_q;
    logic [31:0]      mem_q [FIFO_DEPTH];

    logic             count_en;
    logic             fifo_empty;
    logic             fifo_full;
    logic             pop;
    logic             push_req;
    logic             push_ok;

    // Increment unless already at the all-ones ceiling.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != '1)) ? v + CNT_W'(1) : v;
    endfunction

    assign count_en = (state_q == ST_RUN) && start_i;

    // Next-state and counter update; clear overrides everything else.
    always_comb begin
        // NOTE: every signal gets a default before any branch, otherwise a path
        // that leaves it unassigned infers a latch.
        state_d  = state_q;
        cycle_d  = cycle_q;
        stall_d  = stall_q;
        flush_d  = flush_q;
        retire_d = retire_q;
        if (clear_i) begin
            state_d  = ST_IDLE;
            cycle_d  = '0;
            stall_d  = '0;
            flush_d  = '0;
            retire_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: if (start_i) state_d = ST_RUN;
                ST_RUN: begin
                    if (start_i) begin
                        cycle_d  = sat_inc(cycle_q, 1'b1);
                        stall_d  = sat_inc(stall_q, stall_i && !jump_i && !branch_i);
                        flush_d  = sat_inc(flush_q, flush_i);
                        retire_d = sat_inc(retire_q, retire_i);
                        if (cycle_d == CNT_W'(MAX_CYCLES)) state_d = ST_DONE;
                    end
                end
                ST_DONE: state_d = ST_DONE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // FSM state and event counters.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= ST_IDLE;
            cycle_q  <= '0;
            stall_q  <= '0;
            flush_q  <= '0;
            retire_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q  <= state_d;
            cycle_q  <= cycle_d;
            stall_q  <= stall_d;
            flush_q  <= flush_d;
            retire_q <= retire_d;
        end
    end

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign pop        = trace.trace_ready_i && !fifo_empty;
    assign push_req   = count_en && flush_i;
    // A pop in the same cycle frees the head slot, so a full FIFO can still accept.
    assign push_ok    = push_req && (!fifo_full || pop);

    // Trace FIFO pointers and sticky overflow flag.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else if (clear_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (pop)     rd_ptr_q <= rd_ptr_q + (PTR_W+1)'(1);
            if (push_ok) wr_ptr_q <= wr_ptr_q + (PTR_W+1)'(1);
            if (push_req && fifo_full && !pop) overflow_q <= 1'b1;
        end
    end

    // Trace FIFO storage write.
    // NOTE: storage is deliberately not reset; the pointers alone define which
    // entries are valid, and trace_pc_o is masked to 0 while empty.
    always_ff @(posedge clk_i) begin
        if (push_ok && !clear_i) mem_q[wr_ptr_q[PTR_W-1:0]] <= pc_i;
    end

    assign cycle_cnt_o         = cycle_q;
    assign stall_cnt_o         = stall_q;
    assign flush_cnt_o         = flush_q;
    assign retire_cnt_o        = retire_q;
    assign running_o           = (state_q == ST_RUN);
    assign done_o              = (state_q == ST_DONE);
    assign overflow_o          = overflow_q;
    assign trace.trace_valid_o = !fifo_empty;
    assign trace.trace_pc_o    = fifo_empty ? 32'h0 : mem_q[rd_ptr_q[PTR_W-1:0]];

endmodule

// File: tb/tb_pipe_perf_monitor.sv
// Directed self-checking bench for pipe_perf_monitor.
module tb_pipe_perf_monitor;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i, clear_i, stall_i, flush_i, jump_i, branch_i, retire_i;
    logic [31:0] pc_i;
    logic [31:0] cycle_cnt_o, stall_cnt_o, flush_cnt_o, retire_cnt_o;
    logic        running_o, done_o, overflow_o;

    int n_tests = 0;
    int n_fail  = 0;

    pipe_perf_monitor_if tif ();

    pipe_perf_monitor #(.CNT_W(32), .MAX_CYCLES(30), .FIFO_DEPTH(8)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .clear_i      (clear_i),
        .stall_i      (stall_i),
        .flush_i      (flush_i),
        .jump_i       (jump_i),
        .branch_i     (branch_i),
        .retire_i     (retire_i),
        .pc_i         (pc_i),
        .cycle_cnt_o  (cycle_cnt_o),
        .stall_cnt_o  (stall_cnt_o),
        .flush_cnt_o  (flush_cnt_o),
        .retire_cnt_o (retire_cnt_o),
        .running_o    (running_o),
        .done_o       (done_o),
        .overflow_o   (overflow_o),
        .trace        (tif)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs are changed and outputs sampled 1 time unit after it.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic idle_inputs();
        stall_i = 0; flush_i = 0; jump_i = 0; branch_i = 0; retire_i = 0;
        pc_i = 32'h0; tif.trace_ready_i = 0;
    endtask

    task automatic do_clear();
        clear_i = 1; start_i = 0;
        tick();
        clear_i = 0;
    endtask

    // Clear, then take the IDLE->RUN edge with start_i held.
    task automatic enter_run();
        do_clear();
        start_i = 1;
        tick();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_cycle"},  cycle_cnt_o, 0);
        check({tag, "_stall"},  stall_cnt_o, 0);
        check({tag, "_flush"},  flush_cnt_o, 0);
        check({tag, "_retire"}, retire_cnt_o, 0);
        check({tag, "_run"},    running_o, 0);
        check({tag, "_done"},   done_o, 0);
        check({tag, "_valid"},  tif.trace_valid_o, 0);
        check({tag, "_pc"},     tif.trace_pc_o, 0);
        check({tag, "_ovf"},    overflow_o, 0);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_i = 0; start_i = 0; clear_i = 0;
        idle_inputs();
        #12;
        check_all_zero("reset");
        rst_i = 1;
        tick();

        // Free run to DONE with no events.
        start_i = 1;
        stall_i = 1; retire_i = 1;            // present on the IDLE->RUN edge: not counted
        tick();
        check("t1_running", running_o, 1);
        check("t1_start_edge_stall", stall_cnt_o, 0);
        check("t1_start_edge_retire", retire_cnt_o, 0);
        stall_i = 0; retire_i = 0;
        tick(30);
        check("t1_cycle", cycle_cnt_o, 30);
        check("t1_done", done_o, 1);
        check("t1_running_off", running_o, 0);
        check("t1_stall", stall_cnt_o, 0);
        check("t1_flush", flush_cnt_o, 0);
        tick();
        check("t1_cycle_frozen", cycle_cnt_o, 30);
        do_clear();
        check("t1_clear_done", done_o, 0);
        check("t1_clear_cycle", cycle_cnt_o, 0);

        // Stall qualification by jump/branch.
        enter_run();
        retire_i = 1;
        stall_i = 1; jump_i = 1;   tick();
        jump_i = 0; branch_i = 1;  tick();
        branch_i = 0;              tick(2);
        idle_inputs();
        check("t2_stall", stall_cnt_o, 2);
        check("t2_retire", retire_cnt_o, 4);
        check("t2_cycle", cycle_cnt_o, 4);

        // Three flushes traced then drained in order.
        enter_run();
        flush_i = 1;
        pc_i = 32'h08; tick();
        pc_i = 32'h0C; tick();
        pc_i = 32'h20; tick();
        idle_inputs();
        check("t3_flush_cnt", flush_cnt_o, 3);
        check("t3_valid", tif.trace_valid_o, 1);
        check("t3_head0", tif.trace_pc_o, 32'h08);
        tif.trace_ready_i = 1;
        tick(); check("t3_head1", tif.trace_pc_o, 32'h0C);
        tick(); check("t3_head2", tif.trace_pc_o, 32'h20);
        tick();
        check("t3_empty", tif.trace_valid_o, 0);
        check("t3_empty_pc", tif.trace_pc_o, 0);
        tick();
        check("t3_pop_empty_valid", tif.trace_valid_o, 0);
        tif.trace_ready_i = 0;

        // Nine flushes into an 8-deep FIFO: last one dropped.
        enter_run();
        flush_i = 1;
        for (int i = 0; i < 9; i++) begin
            pc_i = 32'(4 * i);
            tick();
        end
        idle_inputs();
        check("t4_flush_cnt", flush_cnt_o, 9);
        check("t4_overflow", overflow_o, 1);
        tif.trace_ready_i = 1;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t4_pop%0d", i), tif.trace_pc_o, 32'(4 * i));
            tick();
        end
        check("t4_drained", tif.trace_valid_o, 0);
        check("t4_overflow_sticky", overflow_o, 1);
        tif.trace_ready_i = 0;

        // Push with simultaneous pop on a full FIFO.
        enter_run();
        flush_i = 1;
        for (int i = 0; i < 8; i++) begin
            pc_i = 32'h100 + 32'(4 * i);
            tick();
        end
        pc_i = 32'h200; tif.trace_ready_i = 1;
        tick();
        flush_i = 0;
        check("t4b_overflow", overflow_o, 0);
        for (int i = 1; i < 8; i++) begin
            check($sformatf("t4b_pop%0d", i), tif.trace_pc_o, 32'h100 + 32'(4 * i));
            tick();
        end
        check("t4b_last", tif.trace_pc_o, 32'h200);
        tick();
        check("t4b_drained", tif.trace_valid_o, 0);
        idle_inputs();

        // Pause mid-RUN: events while start_i is low are ignored.
        enter_run();
        tick(10);
        start_i = 0; stall_i = 1; flush_i = 1; retire_i = 1; pc_i = 32'h44;
        tick(5);
        check("t5_hold_cycle", cycle_cnt_o, 10);
        check("t5_hold_stall", stall_cnt_o, 0);
        check("t5_hold_flush", flush_cnt_o, 0);
        check("t5_hold_retire", retire_cnt_o, 0);
        check("t5_hold_valid", tif.trace_valid_o, 0);
        check("t5_hold_running", running_o, 1);
        idle_inputs();
        start_i = 1;
        tick(19);
        check("t5_cycle29", cycle_cnt_o, 29);
        check("t5_not_done", done_o, 0);
        tick();
        check("t5_cycle30", cycle_cnt_o, 30);
        check("t5_done", done_o, 1);

        // Asynchronous reset between edges mid-RUN.
        enter_run();
        retire_i = 1; tick(3);
        retire_i = 0; flush_i = 1; pc_i = 32'h44; tick();
        idle_inputs();
        check("t6_pre_retire", retire_cnt_o, 3);
        check("t6_pre_valid", tif.trace_valid_o, 1);
        #1 rst_i = 0;
        #1 check_all_zero("t6_async");
        rst_i = 1;
        start_i = 0;
        tick();
        check("t6_idle_after", running_o, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
